systolic_pe_param: RTL and testbench
====================================

Name: systolic_pe_param

Overview:
Parametrised successor to the team's single-width systolic square/PE cell. It forwards A/B operands to its east/south neighbours one cycle later and accumulates K_DEPTH multiply-accumulate beats into one tile result. Over the original cell it adds:
- valid-qualified beats with bubble tolerance
- back-to-back tiles
- signed/unsigned mode
- saturating or wrapping output narrowing
- a sticky overflow flag and synchronous clear

It is the building block for the next N x N systolic array.

Parameters:
DATA_W, 8, operand width of a/b.
ACC_W, 20, accumulator width; must be >= 2*DATA_W.
OUT_W, 8, width of narrowed result c_out; must be <= ACC_W.
K_DEPTH, 3, MAC beats per tile; must be >= 1.
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.
SATURATE, 1, 1 = clamp c_out to the OUT_W range, 0 = truncate to acc[OUT_W-1:0].

Ports:
CLK  in  1  single clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
clear_in  in  1  synchronous tile abort/clear.
valid_in  in  1  a_in/b_in carry a MAC beat (the PERFORM_NEXT_OPERATION equivalent).
a_in  in  DATA_W  operand A from the west.
b_in  in  DATA_W  operand B from the north.
a_out  out  DATA_W  registered a_in, to the east.
b_out  out  DATA_W  registered b_in, to the south.
valid_out  out  1  registered valid_in.
done  out  1  tile result valid; level signal.
c_out  out  OUT_W  narrowed tile result.
c_full  out  ACC_W  raw accumulator.
overflow  out  1  sticky accumulator overflow for the current tile.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - a_out, b_out, valid_out, done, c_out, c_full, overflow all = 0.
  - beat count = 0; state = IDLE.
- Pass-through:
  - Every edge: a_out<=a_in, b_out<=b_in, valid_out<=valid_in.
  - Pass-through ignores state, clear_in and done, so latency is exactly 1 cycle.
- Product:
  - 2*DATA_W bits, signed or unsigned per SIGNED.
  - Sign- or zero-extended to ACC_W, then added to acc modulo 2^ACC_W.
- Overflow:
  - Set when an add overflows ACC_W: unsigned carry-out, or signed overflow.
  - Sticky until the next tile start, clear_in or RESET.
- Beat counter:
  - Counts 1..K_DEPTH.
  - Width is clog2(K_DEPTH+1).
- States: IDLE, ACCUM, DONE.
  - IDLE:
    - valid_in: acc <= product, count <= 1, overflow <= 0.
    - Goes to DONE if K_DEPTH == 1, else to ACCUM.
  - ACCUM:
    - valid_in: acc += product, count++.
    - When count reaches K_DEPTH, go to DONE.
    - valid_in = 0 is a bubble: acc, count and state hold.
  - DONE:
    - done = 1; c_out holds.
    - valid_in starts the next tile exactly as from IDLE, on the same edge. No dead cycle.
    - done drops on that edge; c_out keeps the old result until the new tile completes.
- Result latency:
  - done and c_out update on the same edge that samples the K_DEPTH-th beat.
  - Both are visible the cycle after that beat is presented.
  - c_out is registered and computed from the post-add accumulator value.
- c_full tracks acc every cycle.
- Narrowing:
  - SATURATE=1, unsigned: c_out = min(acc, 2^OUT_W-1).
  - SATURATE=1, signed: c_out = acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SATURATE=0: c_out = acc[OUT_W-1:0].
  - If overflow=1 and SATURATE=1, c_out = the max or min, in the direction of the lost carry.
- clear_in:
  - Highest synchronous priority; beats on the same edge are discarded.
  - acc, count, done, c_out and overflow go to 0; state goes to IDLE.
  - Pass-through is unaffected.
- RESET mid-tile abandons all partial state; the first beat after release starts a fresh tile.
- Operand changes while valid_in = 0 have no effect on acc.

Test Plan:
1. Defaults, RESET pulse, then beats (1,10),(2,13),(3,16) on consecutive cycles:
   - done=1 and c_out=84 (10+26+48) the cycle after beat 3.
   - a_out/b_out/valid_out follow inputs by 1 cycle.
2. Same three beats with valid_in=0 for 2 cycles between beats 2 and 3:
   - c_out=84, done rises 2 cycles later than in case 1.
   - Operands driven during the bubble are ignored.
3. Beats (200,200) x3:
   - c_full=120000, c_out=255, overflow=0.
   - Repeat with SATURATE=0: c_out=192.
   - Repeat with ACC_W=16 and (255,255) x3: overflow=1, c_out=255.
4. After case 1 completes, beats (1,1) x3 back-to-back:
   - done falls 1 cycle after the first new beat; c_out stays 84.
   - Then done=1 and c_out=3 the cycle after the third beat. No idle cycle is required.
5. RESET asserted asynchronously between clock edges after 2 beats:
   - All outputs go to 0 before the next edge.
   - After release, beats (2,2) x3 give c_out=12.
   - Also: clear_in together with valid_in on beat 2 → beat discarded; three further beats (1,5) give c_out=15.
6. SIGNED=1, beats (-3,4),(-2,5),(1,1):
   - c_full = -21 (two's complement), c_out = 8'hEB.
   - Beats (-128,-128) x3 → c_out=127 (saturated positive).

Source files
------------

// File: rtl/systolic_pe_param.sv
// ============================================================================
// Module   : systolic_pe_param
// Purpose  : Systolic MAC cell. Forwards operands east/south and accumulates
//            K_DEPTH beats per tile into a narrowed result.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module systolic_pe_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int OUT_W    = 8,
    parameter int K_DEPTH  = 3,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              done,
    output logic [OUT_W-1:0]  c_out,
    output logic [ACC_W-1:0]  c_full,
    output logic              overflow
);

    localparam int CNT_W  = $clog2(K_DEPTH + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_DEPTH);
    // Output range limits expressed at accumulator width for direct compares.
    localparam logic [ACC_W-1:0] U_MAX = ~({ACC_W{1'b1}} << OUT_W);
    localparam logic [ACC_W-1:0] S_MAX = U_MAX >> 1;
    localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               ovf_n, ovf_pos, pos_n;
    logic [OUT_W-1:0]   cout_n;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf, add_pos;

    generate
        if (SIGNED != 0) begin : g_signed
            assign prod     = $signed(a_in) * $signed(b_in);
            assign prod_ext = ACC_W'($signed(prod));
        end else begin : g_unsigned
            assign prod     = a_in * b_in;
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

    assign sum_wide = {1'b0, acc} + {1'b0, prod_ext};
    assign sum      = sum_wide[ACC_W-1:0];

    always_comb begin
        if (SIGNED != 0) begin
            add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
            add_pos = ~acc[ACC_W-1];
        end else begin
            add_ovf = sum_wide[ACC_W];
            add_pos = 1'b1;
        end
    end

    // pos selects the clamp direction once the accumulator has lost a carry.
    function automatic logic [OUT_W-1:0] narrow(input logic [ACC_W-1:0] v,
                                                 input logic ov, input logic pos);
        logic [OUT_W-1:0] r;
        r = v[OUT_W-1:0];
        if (SATURATE != 0) begin
            if (SIGNED != 0) begin
                if (ov)
                    r = pos ? S_MAX[OUT_W-1:0] : S_MIN[OUT_W-1:0];
                else if ($signed(v) > $signed(S_MAX))
                    r = S_MAX[OUT_W-1:0];
                else if ($signed(v) < $signed(S_MIN))
                    r = S_MIN[OUT_W-1:0];
            end else begin
                if (ov || (v > U_MAX))
                    r = U_MAX[OUT_W-1:0];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = overflow;
        pos_n   = ovf_pos;
        cout_n  = c_out;
        if (clear_in) begin
            state_n = S_IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            pos_n   = 1'b0;
            cout_n  = '0;
        end else if (valid_in) begin
            case (state)
                S_IDLE, S_DONE: begin
                    acc_n = prod_ext;
                    cnt_n = CNT_W'(1);
                    ovf_n = 1'b0;
                    pos_n = 1'b0;
                    if (K_DEPTH == 1) begin
                        state_n = S_DONE;
                        cout_n  = narrow(prod_ext, 1'b0, 1'b0);
                    end else begin
                        state_n = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_n = sum;
                    cnt_n = cnt + 1'b1;
                    ovf_n = overflow | add_ovf;
                    pos_n = add_ovf ? add_pos : ovf_pos;
                    if (cnt_n == K_LAST) begin
                        state_n = S_DONE;
                        cout_n  = narrow(sum, ovf_n, pos_n);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            ovf_pos  <= 1'b0;
            c_out    <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            overflow <= ovf_n;
            ovf_pos  <= pos_n;
            c_out    <= cout_n;
        end
    end

    // Operand forwarding is independent of the tile state machine.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= valid_in;
        end
    end

    assign done   = (state == S_DONE);
    assign c_full = acc;

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe_param.sv
// ============================================================================
// Module   : tb_systolic_pe_param
// Purpose  : Scoreboard bench for systolic_pe_param across four configurations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_pe_param;

    localparam int N = 4;
    localparam int K = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       clear_in = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;

    always #5 CLK = ~CLK;

    logic [7:0]  a_o  [N];
    logic [7:0]  b_o  [N];
    logic        v_o  [N];
    logic        d_o  [N];
    logic [7:0]  c_o  [N];
    logic        ov_o [N];
    logic [19:0] cf_o [N];
    logic [19:0] cf20 [3];
    logic [15:0] cf16;

    // 0: unsigned/saturate, 1: unsigned/wrap, 2: 16-bit accumulator, 3: signed
    int cfg_w   [N] = '{20, 20, 16, 20};
    int cfg_sgn [N] = '{0, 0, 0, 1};
    int cfg_sat [N] = '{1, 0, 1, 1};

    systolic_pe_param #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .K_DEPTH(K), .SIGNED(0), .SATURATE(1)) u_base (
        .CLK(CLK), .RESET(RESET), .clear_in(clear_in), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(v_o[0]), .done(d_o[0]), .c_out(c_o[0]),
        .c_full(cf20[0]), .overflow(ov_o[0]));
    systolic_pe_param #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .K_DEPTH(K), .SIGNED(0), .SATURATE(0)) u_wrap (
        .CLK(CLK), .RESET(RESET), .clear_in(clear_in), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(v_o[1]), .done(d_o[1]), .c_out(c_o[1]),
        .c_full(cf20[1]), .overflow(ov_o[1]));
    systolic_pe_param #(.DATA_W(8), .ACC_W(16), .OUT_W(8), .K_DEPTH(K), .SIGNED(0), .SATURATE(1)) u_acc16 (
        .CLK(CLK), .RESET(RESET), .clear_in(clear_in), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_o[2]), .b_out(b_o[2]), .valid_out(v_o[2]), .done(d_o[2]), .c_out(c_o[2]),
        .c_full(cf16), .overflow(ov_o[2]));
    systolic_pe_param #(.DATA_W(8), .ACC_W(20), .OUT_W(8), .K_DEPTH(K), .SIGNED(1), .SATURATE(1)) u_sgn (
        .CLK(CLK), .RESET(RESET), .clear_in(clear_in), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_o[3]), .b_out(b_o[3]), .valid_out(v_o[3]), .done(d_o[3]), .c_out(c_o[3]),
        .c_full(cf20[2]), .overflow(ov_o[3]));

    assign cf_o[0] = cf20[0];
    assign cf_o[1] = cf20[1];
    assign cf_o[2] = {4'b0, cf16};
    assign cf_o[3] = cf20[2];

    typedef struct {
        logic [7:0] cout;
        longint     cfull;
        bit         ov;
        int         cyc;
    } exp_t;

    exp_t       sbq [N][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    // Reference model: tile contents as mathematical integers
    int         nb      [N];
    longint     acc     [N];
    bit         ovf     [N];
    bit         pos     [N];
    bit         done_e  [N];
    logic [7:0] cout_e  [N];
    bit         prev_d  [N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mask_of(int i);
        return (64'sd1 <<< cfg_w[i]) - 1;
    endfunction

    function automatic logic [7:0] narrow_ref(int i);
        longint lo, hi, v;
        lo = cfg_sgn[i] != 0 ? -128 : 0;
        hi = cfg_sgn[i] != 0 ? 127 : 255;
        v  = acc[i];
        if (cfg_sat[i] != 0) begin
            if (ovf[i])      v = pos[i] ? hi : lo;
            else if (v > hi) v = hi;
            else if (v < lo) v = lo;
        end
        return v[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            nb[i] = 0; acc[i] = 0; ovf[i] = 0; pos[i] = 0;
            done_e[i] = 0; cout_e[i] = '0;
        end
    endtask

    task automatic model_beat(input bit v, input logic [7:0] a, input logic [7:0] b, input bit clr);
        longint p, s, lo, hi, span;
        for (int i = 0; i < N; i++) begin
            span = 64'sd1 <<< cfg_w[i];
            lo   = cfg_sgn[i] != 0 ? -(span / 2) : 0;
            hi   = cfg_sgn[i] != 0 ? (span / 2) - 1 : span - 1;
            if (clr) begin
                nb[i] = 0; acc[i] = 0; ovf[i] = 0; pos[i] = 0;
                done_e[i] = 0; cout_e[i] = '0;
            end else if (v) begin
                if (cfg_sgn[i] != 0) p = longint'($signed(a)) * longint'($signed(b));
                else                 p = longint'(a) * longint'(b);
                if (nb[i] == 0 || nb[i] == K) begin
                    acc[i] = p; nb[i] = 1; ovf[i] = 0; pos[i] = 0; done_e[i] = 0;
                end else begin
                    s = acc[i] + p;
                    if (s > hi) begin s = s - span; ovf[i] = 1; pos[i] = 1; end
                    else if (s < lo) begin s = s + span; ovf[i] = 1; pos[i] = 0; end
                    acc[i] = s;
                    nb[i]++;
                end
                if (nb[i] == K) begin
                    done_e[i] = 1;
                    cout_e[i] = narrow_ref(i);
                    sbq[i].push_back('{cout: cout_e[i], cfull: acc[i] & mask_of(i),
                                       ov: ovf[i], cyc: cyc + 1});
                end
            end
        end
    endtask

    // One call per clock: inputs change on the falling edge only.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit clr = 1'b0, input bit rst = 1'b0);
        @(negedge CLK);
        RESET = rst; valid_in = v; a_in = a; b_in = b; clear_in = clr;
        if (rst) model_reset();
        else     model_beat(v, a, b, clr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_aout[%0d]", tag, i), a_o[i], 0);
            chk($sformatf("%s_bout[%0d]", tag, i), b_o[i], 0);
            chk($sformatf("%s_vout[%0d]", tag, i), v_o[i], 0);
            chk($sformatf("%s_done[%0d]", tag, i), d_o[i], 0);
            chk($sformatf("%s_cout[%0d]", tag, i), c_o[i], 0);
            chk($sformatf("%s_cfull[%0d]", tag, i), cf_o[i], 0);
            chk($sformatf("%s_ovf[%0d]", tag, i), ov_o[i], 0);
        end
    endtask

    // Monitor: per-cycle level checks plus scoreboard pop on each done rise.
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("a_out[%0d]", i), a_o[i], RESET ? 0 : a_in);
            chk($sformatf("b_out[%0d]", i), b_o[i], RESET ? 0 : b_in);
            chk($sformatf("valid_out[%0d]", i), v_o[i], RESET ? 0 : valid_in);
            chk($sformatf("done[%0d]", i), d_o[i], done_e[i]);
            chk($sformatf("c_out[%0d]", i), c_o[i], cout_e[i]);
            chk($sformatf("c_full[%0d]", i), cf_o[i], acc[i] & mask_of(i));
            chk($sformatf("overflow[%0d]", i), ov_o[i], ovf[i]);
            if (d_o[i] && !prev_d[i]) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("sb_unexpected_done[%0d]", i), 1, 0);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("sb_cout[%0d]", i), c_o[i], e.cout);
                    chk($sformatf("sb_cfull[%0d]", i), cf_o[i], e.cfull);
                    chk($sformatf("sb_ovf[%0d]", i), ov_o[i], e.ov);
                    chk($sformatf("sb_cycle[%0d]", i), cyc, e.cyc);
                end
            end
            prev_d[i] = d_o[i];
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) prev_d[i] = 0;
        #1 RESET = 1'b1;
        #1 check_all_zero("por");
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(2);

        // Basic tile, then with a two-cycle bubble
        step(1, 1, 10); step(1, 2, 13); step(1, 3, 16);
        idle(1);
        chk("t1_done", d_o[0], 1);
        chk("t1_cout", c_o[0], 84);
        step(1, 1, 10); step(1, 2, 13); idle(2); step(1, 3, 16);
        idle(1);
        chk("t2_cout", c_o[0], 84);

        // Narrowing and overflow
        step(1, 200, 200); step(1, 200, 200); step(1, 200, 200);
        idle(1);
        chk("t3_cfull", cf_o[0], 120000);
        chk("t3_cout_sat", c_o[0], 255);
        chk("t3_ovf", ov_o[0], 0);
        chk("t3_cout_wrap", c_o[1], 192);
        step(1, 255, 255); step(1, 255, 255); step(1, 255, 255);
        idle(1);
        chk("t3_acc16_ovf", ov_o[2], 1);
        chk("t3_acc16_cout", c_o[2], 255);

        // Back-to-back tiles
        step(1, 1, 10); step(1, 2, 13); step(1, 3, 16);
        step(1, 1, 1);
        step(1, 1, 1);
        chk("t4_done_fell", d_o[0], 0);
        chk("t4_cout_held", c_o[0], 84);
        step(1, 1, 1);
        idle(1);
        chk("t4_done", d_o[0], 1);
        chk("t4_cout", c_o[0], 3);

        // Asynchronous reset mid-tile, then clear with a beat
        step(1, 1, 10); step(1, 2, 13); step(0, 7, 9);
        #2 RESET = 1'b1;
        model_reset();
        #1 check_all_zero("areset");
        step(0, 0, 0, 0, 1);
        step(1, 2, 2); step(1, 2, 2); step(1, 2, 2);
        idle(1);
        chk("t5_cout", c_o[0], 12);
        step(1, 1, 5); step(1, 1, 5, 1);
        step(1, 1, 5); step(1, 1, 5); step(1, 1, 5);
        idle(1);
        chk("t5_clear_cout", c_o[0], 15);

        // Signed mode
        step(1, 8'hFD, 8'h04); step(1, 8'hFE, 8'h05); step(1, 8'h01, 8'h01);
        idle(1);
        chk("t6_cfull", cf_o[3], 20'hFFFEB);
        chk("t6_cout", c_o[3], 8'hEB);
        step(1, 8'h80, 8'h80); step(1, 8'h80, 8'h80); step(1, 8'h80, 8'h80);
        idle(1);
        chk("t6_sat_pos", c_o[3], 127);

        // Random traffic with bubbles and occasional clears
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < 4);
        end
        idle(4);
        for (int i = 0; i < N; i++) chk($sformatf("sb_drained[%0d]", i), sbq[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
